// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one memory-style register port between two requesters.
// Every access runs grant (IDLE) -> downstream strobe (ACCESS) -> response capture (RESP).
module reg_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_m0_req,
  input  logic            i_m0_we,
  input  logic [AW-1:0]   i_m0_addr,
  input  logic [DW/8-1:0] i_m0_be,
  input  logic [DW-1:0]   i_m0_wdata,
  output logic            o_m0_gnt,
  output logic            o_m0_rvalid,
  output logic [DW-1:0]   o_m0_rdata,
  input  logic            i_m1_req,
  input  logic            i_m1_we,
  input  logic [AW-1:0]   i_m1_addr,
  input  logic [DW/8-1:0] i_m1_be,
  input  logic [DW-1:0]   i_m1_wdata,
  output logic            o_m1_gnt,
  output logic            o_m1_rvalid,
  output logic [DW-1:0]   o_m1_rdata,
  output logic            o_reg_we,
  output logic [AW-1:0]   o_reg_addr,
  output logic [DW/8-1:0] o_reg_be,
  output logic [DW-1:0]   o_reg_wdata,
  output logic            o_reg_req,
  input  logic [DW-1:0]   i_reg_rdata
);
  localparam int BW = DW / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t        r_state, w_next;
  logic          r_prio, r_owner, r_we;
  logic          r_rvalid0, r_rvalid1;
  logic [AW-1:0] r_addr;
  logic [BW-1:0] r_be;
  logic [DW-1:0] r_wdata, r_rdata0, r_rdata1;
  logic          w_gnt0, w_gnt1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // r_prio names the requester that wins a tie; grants are suppressed while in reset.
  always_comb begin
    w_next    = r_state;
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    o_reg_req = 1'b0;
    o_reg_we  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst) begin
          if (i_m0_req && (!i_m1_req || !r_prio)) w_gnt0 = 1'b1;
          else if (i_m1_req)                       w_gnt1 = 1'b1;
        end
        if (w_gnt0 || w_gnt1) w_next = ACCESS;
      end
      ACCESS: begin
        o_reg_req = 1'b1;
        o_reg_we  = r_we;
        w_next    = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio    <= 1'b0;
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      if (w_gnt0) begin
        r_owner <= 1'b0;
        r_prio  <= 1'b1;
        r_we    <= i_m0_we;
        r_addr  <= i_m0_addr;
        r_be    <= i_m0_be;
        r_wdata <= i_m0_wdata;
      end else if (w_gnt1) begin
        r_owner <= 1'b1;
        r_prio  <= 1'b0;
        r_we    <= i_m1_we;
        r_addr  <= i_m1_addr;
        r_be    <= i_m1_be;
        r_wdata <= i_m1_wdata;
      end
      // Writes complete with rvalid too, but only reads overwrite the owner's rdata.
      if (r_state == RESP) begin
        if (r_owner) begin
          r_rvalid1 <= 1'b1;
          if (!r_we) r_rdata1 <= i_reg_rdata;
        end else begin
          r_rvalid0 <= 1'b1;
          if (!r_we) r_rdata0 <= i_reg_rdata;
        end
      end
    end
  end

  assign o_m0_gnt    = w_gnt0;
  assign o_m1_gnt    = w_gnt1;
  assign o_m0_rvalid = r_rvalid0;
  assign o_m1_rvalid = r_rvalid1;
  assign o_m0_rdata  = r_rdata0;
  assign o_m1_rdata  = r_rdata1;
  assign o_reg_addr  = r_addr;
  assign o_reg_be    = r_be;
  assign o_reg_wdata = r_wdata;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed scenarios plus random traffic, all checked against
// a transaction-timing reference model (grant at t, strobe at t+1, completion at t+3).
module tb_reg_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int VW = 4 + 2 * DW + 2 + AW + BW + DW;

  logic clk = 1'b0;
  logic rst;
  logic i_m0_req, i_m0_we, i_m1_req, i_m1_we;
  logic [AW-1:0] i_m0_addr, i_m1_addr;
  logic [BW-1:0] i_m0_be, i_m1_be;
  logic [DW-1:0] i_m0_wdata, i_m1_wdata, i_reg_rdata;
  logic o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid, o_reg_we, o_reg_req;
  logic [DW-1:0] o_m0_rdata, o_m1_rdata, o_reg_wdata;
  logic [AW-1:0] o_reg_addr;
  logic [BW-1:0] o_reg_be;

  always #5 clk = ~clk;

  reg_bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .i_m0_req(i_m0_req), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr), .i_m0_be(i_m0_be),
    .i_m0_wdata(i_m0_wdata), .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
    .i_m1_req(i_m1_req), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr), .i_m1_be(i_m1_be),
    .i_m1_wdata(i_m1_wdata), .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
    .o_reg_we(o_reg_we), .o_reg_addr(o_reg_addr), .o_reg_be(o_reg_be), .o_reg_wdata(o_reg_wdata),
    .o_reg_req(o_reg_req), .i_reg_rdata(i_reg_rdata)
  );

  logic [VW-1:0] obsVec, expVec;
  assign obsVec = {o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_m0_rdata, o_m1_rdata,
                   o_reg_req, o_reg_we, o_reg_addr, o_reg_be, o_reg_wdata};

  int checks = 0;
  int errors = 0;

  // Reference model: time-stamped transaction bookkeeping rather than a state machine.
  int cyc, freeAt, grantCyc, rvalidAt;
  bit mPrio, inFlight, own, rvOwn, accWe, eG0, eG1;
  logic [AW-1:0] hAddr;
  logic [BW-1:0] hBe;
  logic [DW-1:0] hWdata, hRdata0, hRdata1;

  task automatic modelInit();
    cyc = 0; freeAt = 0; grantCyc = -10; rvalidAt = -1;
    mPrio = 0; inFlight = 0; own = 0; rvOwn = 0; accWe = 0;
    hAddr = '0; hBe = '0; hWdata = '0; hRdata0 = '0; hRdata1 = '0;
  endtask

  task automatic computeExpected();
    bit eReq;
    eG0 = 0;
    eG1 = 0;
    if (!rst && cyc >= freeAt) begin
      if (i_m0_req && i_m1_req) begin
        eG0 = !mPrio;
        eG1 = mPrio;
      end else begin
        eG0 = i_m0_req;
        eG1 = i_m1_req;
      end
    end
    eReq = inFlight && (cyc == grantCyc + 1);
    expVec = {eG0, eG1, (cyc == rvalidAt) && !rvOwn, (cyc == rvalidAt) && rvOwn,
              hRdata0, hRdata1, eReq, eReq && accWe, hAddr, hBe, hWdata};
  endtask

  task automatic modelEdge();
    if (rst) begin
      freeAt = cyc + 1; mPrio = 0; inFlight = 0; rvalidAt = -1;
      hAddr = '0; hBe = '0; hWdata = '0; hRdata0 = '0; hRdata1 = '0;
    end else begin
      if (inFlight && cyc == grantCyc + 2) begin
        rvalidAt = cyc + 1;
        rvOwn = own;
        if (!accWe) begin
          if (own) hRdata1 = i_reg_rdata;
          else     hRdata0 = i_reg_rdata;
        end
        inFlight = 0;
      end
      if (eG0 || eG1) begin
        own = eG1; inFlight = 1; grantCyc = cyc; freeAt = cyc + 3; mPrio = eG0;
        accWe  = eG1 ? i_m1_we    : i_m0_we;
        hAddr  = eG1 ? i_m1_addr  : i_m0_addr;
        hBe    = eG1 ? i_m1_be    : i_m0_be;
        hWdata = eG1 ? i_m1_wdata : i_m0_wdata;
      end
    end
    cyc++;
  endtask

  task automatic settle();
    @(negedge clk);
    computeExpected();
  endtask

  task automatic advance();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic randFields();
    i_m0_we = 1'($urandom); i_m0_addr = $urandom; i_m0_be = BW'($urandom); i_m0_wdata = {$urandom, $urandom};
    i_m1_we = 1'($urandom); i_m1_addr = $urandom; i_m1_be = BW'($urandom); i_m1_wdata = {$urandom, $urandom};
    i_reg_rdata = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    i_m0_req = 1; i_m1_req = 1;
    settle();
    checks++;
    if (obsVec !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: got %h want 0", obsVec);
    end
    checks++;
    if (obsVec !== expVec) begin
      errors++;
      $display("[TB] FAIL reset_model: got %h want %h", obsVec, expVec);
    end
    advance();
    rst = 0; i_m0_req = 0; i_m1_req = 0;
  endtask

  task automatic test_single_read();
    logic [DW-1:0] m1Before;
    m1Before = o_m1_rdata;
    for (int c = 0; c < 5; c++) begin
      randFields();
      i_m0_req = (c == 0); i_m0_we = 0; i_m0_addr = 32'h8000_1000; i_m1_req = 0;
      i_reg_rdata = 64'h0123_4567_89AB_CDEF;
      settle();
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL read_cycle%0d: got %h want %h", c, obsVec, expVec);
      end
      if (c == 0) begin
        checks++;
        if ({o_m0_gnt, o_m1_gnt} !== 2'b10) begin
          errors++;
          $display("[TB] FAIL read_gnt: got %b want 10", {o_m0_gnt, o_m1_gnt});
        end
      end
      if (c == 1) begin
        checks++;
        if ({o_reg_req, o_reg_we, o_reg_addr} !== {2'b10, 32'h8000_1000}) begin
          errors++;
          $display("[TB] FAIL read_strobe: got %b%b %h want 10 80001000", o_reg_req, o_reg_we, o_reg_addr);
        end
      end
      if (c == 3) begin
        checks++;
        if ({o_m0_rvalid, o_m0_rdata} !== {1'b1, 64'h0123_4567_89AB_CDEF}) begin
          errors++;
          $display("[TB] FAIL read_rvalid: got %b %h want 1 0123456789abcdef", o_m0_rvalid, o_m0_rdata);
        end
      end
      checks++;
      if (o_m1_rvalid !== 1'b0 || o_m1_rdata !== m1Before) begin
        errors++;
        $display("[TB] FAIL read_m1_quiet: got %b %h want 0 %h", o_m1_rvalid, o_m1_rdata, m1Before);
      end
      advance();
    end
  endtask

  task automatic test_single_write();
    logic [DW-1:0] m1Before;
    int pulses = 0;
    m1Before = o_m1_rdata;
    for (int c = 0; c < 5; c++) begin
      randFields();
      i_m0_req = 0; i_m1_req = (c == 0); i_m1_we = 1; i_m1_addr = 32'h28;
      i_m1_be = 8'h0F; i_m1_wdata = 64'hDEAD_BEEF;
      settle();
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL write_cycle%0d: got %h want %h", c, obsVec, expVec);
      end
      if (o_reg_req === 1'b1) begin
        pulses++;
        checks++;
        if ({o_reg_we, o_reg_addr, o_reg_be, o_reg_wdata} !== {1'b1, 32'h28, 8'h0F, 64'hDEAD_BEEF}) begin
          errors++;
          $display("[TB] FAIL write_fields: got %b %h %h %h want 1 00000028 0f deadbeef",
                   o_reg_we, o_reg_addr, o_reg_be, o_reg_wdata);
        end
      end
      if (c == 3) begin
        checks++;
        if (o_m1_rvalid !== 1'b1 || o_m1_rdata !== m1Before) begin
          errors++;
          $display("[TB] FAIL write_rvalid: got %b %h want 1 %h", o_m1_rvalid, o_m1_rdata, m1Before);
        end
      end
      advance();
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("[TB] FAIL write_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_contention();
    bit gWho[$];
    int gCyc[$];
    rst = 1; i_m0_req = 0; i_m1_req = 0;
    settle();
    advance();
    rst = 0;
    for (int c = 0; c < 20; c++) begin
      randFields();
      i_m0_req = (c < 16); i_m1_req = (c < 16);
      settle();
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL contend_cycle%0d: got %h want %h", c, obsVec, expVec);
      end
      if (o_m0_gnt === 1'b1) begin gWho.push_back(1'b0); gCyc.push_back(c); end
      if (o_m1_gnt === 1'b1) begin gWho.push_back(1'b1); gCyc.push_back(c); end
      advance();
    end
    checks++;
    if (gWho.size() != 6) begin
      errors++;
      $display("[TB] FAIL contend_count: got %0d want 6", gWho.size());
    end
    for (int i = 0; i < gWho.size() && i < 6; i++) begin
      checks++;
      if (gWho[i] !== 1'(i % 2) || gCyc[i] !== 3 * i) begin
        errors++;
        $display("[TB] FAIL contend_order%0d: got m%0d at %0d want m%0d at %0d", i, gWho[i], gCyc[i], i % 2, 3 * i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int gCyc[$];
    int rCyc[$];
    for (int c = 0; c < 17; c++) begin
      randFields();
      i_m0_req = (c < 13); i_m1_req = 0;
      settle();
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL b2b_cycle%0d: got %h want %h", c, obsVec, expVec);
      end
      if (o_m0_gnt === 1'b1) gCyc.push_back(c);
      if (o_m0_rvalid === 1'b1) rCyc.push_back(c);
      advance();
    end
    checks++;
    if (gCyc.size() != 5 || rCyc.size() != 5) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d grants %0d rvalids want 5 5", gCyc.size(), rCyc.size());
    end
    for (int i = 0; i < 5 && i < gCyc.size() && i < rCyc.size(); i++) begin
      checks++;
      if (gCyc[i] !== 3 * i || rCyc[i] !== 3 * i + 3) begin
        errors++;
        $display("[TB] FAIL b2b_timing%0d: got gnt %0d rvalid %0d want %0d %0d", i, gCyc[i], rCyc[i], 3 * i, 3 * i + 3);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    for (int c = 0; c < 12; c++) begin
      randFields();
      rst = (c == 1);
      i_m0_req = (c == 0) || (c == 4);
      if (c == 0) i_m0_we = 1;
      i_m1_req = (c >= 4) && (c <= 7);
      settle();
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL rstmid_cycle%0d: got %h want %h", c, obsVec, expVec);
      end
      if (c == 1) begin
        checks++;
        if ({o_reg_req, o_reg_we} !== 2'b11) begin
          errors++;
          $display("[TB] FAIL rstmid_strobe: got %b want 11", {o_reg_req, o_reg_we});
        end
      end
      if (c >= 2 && c <= 6) begin
        checks++;
        if ({o_reg_req, o_reg_we, o_m0_rvalid, o_m1_rvalid} !== 4'b0000 && c != 5) begin
          errors++;
          $display("[TB] FAIL rstmid_quiet%0d: got %b want 0000", c, {o_reg_req, o_reg_we, o_m0_rvalid, o_m1_rvalid});
        end
      end
      if (c == 4) begin
        checks++;
        if ({o_m0_gnt, o_m1_gnt} !== 2'b10) begin
          errors++;
          $display("[TB] FAIL rstmid_prio: got %b want 10", {o_m0_gnt, o_m1_gnt});
        end
      end
      advance();
    end
    rst = 0;
  endtask

  task automatic test_withdrawn();
    int pulses = 0;
    for (int c = 0; c < 7; c++) begin
      randFields();
      i_m0_req = (c == 0);
      i_m1_req = (c == 1) || (c == 2);
      settle();
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL withdraw_cycle%0d: got %h want %h", c, obsVec, expVec);
      end
      checks++;
      if (o_m1_gnt !== 1'b0) begin
        errors++;
        $display("[TB] FAIL withdraw_gnt%0d: got %b want 0", c, o_m1_gnt);
      end
      if (o_reg_req === 1'b1) pulses++;
      advance();
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("[TB] FAIL withdraw_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_random();
    bit want0 = 0;
    bit want1 = 0;
    for (int c = 0; c < 400; c++) begin
      randFields();
      rst = ($urandom_range(0, 59) == 0);
      if (!want0) want0 = 1'($urandom);
      else if ($urandom_range(0, 9) == 0) want0 = 0;
      if (!want1) want1 = 1'($urandom);
      else if ($urandom_range(0, 9) == 0) want1 = 0;
      i_m0_req = want0; i_m1_req = want1;
      settle();
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d: got %h want %h", c, obsVec, expVec);
      end
      if (eG0) want0 = 0;
      if (eG1) want1 = 0;
      advance();
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    i_m0_req = 0; i_m1_req = 0;
    randFields();
    repeat (2) @(posedge clk);
    #1;
    modelInit();
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_back_to_back();
    test_reset_mid_access();
    test_withdrawn();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Round-robin arbiter that shares one simple memory-style register port between two requesters.
- The shared port is the we/addr/be/wdata/rdata interface that the SoC controller exposes after AXI-to-memory conversion. Example requesters: the AXI-converted CPU path and a debug/boot loader path.
- Sequences each access as grant, then downstream strobe, then response. Returns read data to the winning requester only.

Parameters:
- AW, 32, address width of requester and downstream ports.
- DW, 64, data width. Byte-enable width is DW/8.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_m0_req  in  1  requester 0 access request; held until o_m0_gnt.
- i_m0_we  in  1  requester 0 write (1) / read (0).
- i_m0_addr  in  AW  requester 0 byte address.
- i_m0_be  in  DW/8  requester 0 byte enables.
- i_m0_wdata  in  DW  requester 0 write data.
- o_m0_gnt  out  1  requester 0 request accepted this cycle.
- o_m0_rvalid  out  1  requester 0 completion pulse.
- o_m0_rdata  out  DW  requester 0 read data, valid with o_m0_rvalid.
- i_m1_req, i_m1_we, i_m1_addr, i_m1_be, i_m1_wdata, o_m1_gnt, o_m1_rvalid, o_m1_rdata: same as m0, for requester 1.
- o_reg_we  out  1  downstream write strobe.
- o_reg_addr  out  AW  downstream address.
- o_reg_be  out  DW/8  downstream byte enables.
- o_reg_wdata  out  DW  downstream write data.
- o_reg_req  out  1  downstream access strobe (reads and writes).
- i_reg_rdata  in  DW  downstream read data; valid one cycle after the o_reg_req cycle.

Behaviour:
- Reset: state=IDLE, prio=0 (m0 favoured).
- Reset values: o_reg_we=0, o_reg_req=0, o_reg_addr=0, o_reg_be=0, o_reg_wdata=0, o_mX_gnt=0, o_mX_rvalid=0, o_mX_rdata=0.
- FSM states: IDLE, ACCESS, RESP. Each access takes exactly 3 cycles; max throughput is one access per 3 cycles.
- IDLE:
  - If neither request is set, stay in IDLE.
  - If one request is set, that requester wins.
  - If both are set, the requester indicated by prio wins.
  - o_mX_gnt for the winner is asserted combinationally in this cycle; at most one gnt is high.
  - On the edge: register the winner's we/addr/be/wdata into the o_reg_* fields, record owner, set prio to the loser, go to ACCESS.
- ACCESS:
  - o_reg_req=1; o_reg_we=1 if the access is a write.
  - No gnt is asserted; new requests wait.
  - Next state is RESP.
- RESP:
  - o_reg_req=0, o_reg_we=0.
  - o_reg_addr, o_reg_be and o_reg_wdata hold their values.
  - On the edge, capture i_reg_rdata into o_<owner>_rdata and pulse o_<owner>_rvalid high for exactly the next cycle. That next cycle is IDLE, so rvalid coincides with the next arbitration.
  - Writes also pulse rvalid as the completion; o_mX_rdata is loaded only for reads and otherwise holds.
- o_mX_rvalid is high for one cycle only. The non-owner's rvalid and rdata never change.
- o_reg_we is never high outside ACCESS. o_reg_we=1 only with o_reg_req=1.
- Fairness: with both requesters continuously requesting, grants alternate m0, m1, m0, ... Neither requester waits more than one other access.
- A request dropped before its gnt is simply not served; no state change.
- Reset asserted mid-access:
  - Next cycle is IDLE; all strobes low; prio=0.
  - No rvalid is emitted for the aborted access.
  - A downstream write already strobed in ACCESS is not undone.

Test Plan:
- Single read: m0 reads 0x8000_1000 while downstream returns 0x0123_4567_89AB_CDEF. Required: o_m0_gnt in cycle 0, o_reg_req with we=0 in cycle 1, o_m0_rvalid with that rdata in cycle 3, m1 outputs untouched.
- Single write: m1 writes be=0x0F, wdata=0xDEAD_BEEF to 0x28. Required: exactly one o_reg_req/o_reg_we pulse with addr=0x28 and be=0x0F, o_m1_rvalid 2 cycles later, o_m1_rdata unchanged.
- Contention from reset: m0 and m1 request in the same cycle. Required: m0 granted first, m1 granted 3 cycles later. Repeat with both held high for 6 accesses; required grant order m0, m1, m0, m1, m0, m1.
- Back-to-back: m0 requests continuously with m1 idle. Required: a grant every 3 cycles and an rvalid every 3 cycles, each aligned with the next grant.
- Reset mid-access: assert rst during ACCESS. Required: o_reg_req=0 next cycle, no rvalid ever for that access; after release, a simultaneous request grants m0 first.
- Request withdrawn: m1 raises req while m0 is in ACCESS, then drops it before IDLE. Required: no o_m1_gnt and no downstream access for m1.
